led_message_scroller: RTL
=========================

// Module: led_message_scroller
// PURPOSE
//  Upstream feeder for the four-digit LED driver. Holds a 16-character message
//  and presents a 4-character window (char3..char0) for the driver to show.
//  The window advances one character per step, wrapping around. Steps come
//  from a debounced push-button, from an auto-scroll timer, or both.
// PARAMETERS
//  MSG              64'h0123456789ABCDEF  message; char i = MSG[63-4i -: 4], i=0..15
//  DEBOUNCE_CYCLES  500000                cycles btn must differ stably (>=1)
//  SCROLL_TICKS     50000000              auto-scroll period in cycles (>=2)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high
//  btn_next     in   1  raw async push-button, active-high
//  auto_en      in   1  1 = auto-scroll enabled (level)
//  char3        out  4  leftmost digit code  = msg[ptr]
//  char2        out  4  msg[(ptr+1) mod 16]
//  char1        out  4  msg[(ptr+2) mod 16]
//  char0        out  4  rightmost digit code = msg[(ptr+3) mod 16]
//  ptr          out  4  current window start index
//  step         out  1  1-cycle pulse, high in the first cycle ptr shows new value
// BEHAVIOUR
//  Reset (overrides all): ptr=0, char3..0=MSG chars 0..3, step=0. Sync flops,
//   btn_db, debounce counter and scroll counter all clear to 0.
//  Sync: btn_next -> 2-flop synchronizer -> btn_s.
//  Debounce, each edge: if btn_s==btn_db, cnt<=0.
//   Else if cnt==DEBOUNCE_CYCLES-1, btn_db<=btn_s and cnt<=0; else cnt<=cnt+1.
//  press = btn_db & ~btn_db_q (rising edge only; release never steps).
//   Bounces shorter than DEBOUNCE_CYCLES are ignored.
//  Latency: btn_next sampled high at edge 1 and held stable -> ptr changes at
//   edge DEBOUNCE_CYCLES+3. A held button gives exactly one step.
//  Timer: auto_en=0 -> tcnt held at 0, no ticks. auto_en=1 -> tcnt counts
//   0..SCROLL_TICKS-1 and wraps. tick = (tcnt==SCROLL_TICKS-1) & auto_en.
//   From tcnt=0, first tick advances ptr at edge SCROLL_TICKS; period is
//   SCROLL_TICKS. Dropping auto_en clears tcnt; re-enabling starts a full period.
//  advance = press | tick. Coincident press and tick give ONE step (ptr+1).
//  On advance: ptr <= ptr+1 mod 16 (15 -> 0). char3..0 are registered and load
//   from the new ptr on the same edge. step is registered from advance.
//  Counter widths come from $clog2 of the parameters. No other state.
//  Button held across reset release: btn_db restarts at 0, so the button
//   re-debounces and produces one step.
// TESTING (bench params DEBOUNCE_CYCLES=4, SCROLL_TICKS=8, 10 ns clock)
//  1 reset 2 cycles, auto_en=0, btn=0 -> ptr=0, chars 0,1,2,3, step=0, held 50 cycles
//  2 auto_en=1 from reset -> ptr++ every 8 edges with 1-cycle step; after 13
//    steps chars=D,E,F,0; after 16 steps ptr=0
//  3 btn bursts of 3 high/1 low x5 -> no step; then btn high 20 cycles -> one
//    step at edge 7 of the hold, ptr 0->1; release -> no step
//  4 auto_en=1, press timed so press and tick coincide -> ptr increases by exactly 1,
//    step high one cycle
//  5 ptr=5 mid-scroll, reset pulsed 1 cycle -> ptr=0, chars 0,1,2,3; next auto
//    step 8 edges after reset release
//  6 auto_en toggled 1->0 at tcnt=5, back to 1 -> no step until 8 edges after re-enable

Source files
------------

// File: rtl/led_message_scroller.sv
// -----------------------------------------------------------------------------
// led_message_scroller
//
// Feeds the four-digit LED driver with a sliding 4-character window over a
// fixed 16-character message. The window start index (ptr) advances by one
// character per step and wraps from 15 back to 0. A step is requested by a
// debounced rising edge of a push-button, by an auto-scroll timer, or both.
// Both sources firing in the same cycle still give a single step.
//
// Parameters
//   MSG              16 x 4-bit message, char i = MSG[63-4i -: 4]
//   DEBOUNCE_CYCLES  cycles the synchronized button must differ stably (>= 1)
//   SCROLL_TICKS     auto-scroll period in clock cycles (>= 2)
//
// Ports
//   clk       in   system clock, everything on the rising edge
//   reset     in   synchronous, active-high, overrides all other activity
//   btn_next  in   raw asynchronous push-button, active-high
//   auto_en   in   level enable for the auto-scroll timer
//   char3     out  leftmost digit code  = msg[ptr]
//   char2     out  msg[ptr+1]
//   char1     out  msg[ptr+2]
//   char0     out  rightmost digit code = msg[ptr+3]
//   ptr       out  current window start index
//   step      out  one-cycle pulse in the first cycle ptr shows a new value
// -----------------------------------------------------------------------------
module led_message_scroller #(
    parameter logic [63:0] MSG             = 64'h0123456789ABCDEF,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SCROLL_TICKS    = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       auto_en,
    output logic [3:0] char3,
    output logic [3:0] char2,
    output logic [3:0] char1,
    output logic [3:0] char0,
    output logic [3:0] ptr,
    output logic       step
);

    // A single-cycle debounce needs no counting, but keep a 1-bit counter so
    // the vector never collapses to zero width.
    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TW  = $clog2(SCROLL_TICKS);

    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  TMax  = TW'(SCROLL_TICKS - 1);

    // ------------------------------------------------------------------
    // Message lookup helpers
    // ------------------------------------------------------------------

    // Character idx sits at the top nibble once the message is shifted left
    // by 4*idx bits.
    function automatic logic [3:0] msg_char(input logic [3:0] idx);
        logic [63:0] sh;
        sh = MSG << {idx, 2'b00};
        return sh[63:60];
    endfunction

    // Packed window {char3, char2, char1, char0} for a given start index;
    // the 4-bit additions wrap modulo 16 on their own.
    function automatic logic [15:0] window_of(input logic [3:0] p);
        return {msg_char(p), msg_char(p + 4'd1), msg_char(p + 4'd2), msg_char(p + 4'd3)};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]     sync_q;
    logic           btn_s;

    logic           btn_db_q, btn_db_d;
    logic           btn_db_dly_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;

    logic [TW-1:0]  tcnt_q, tcnt_d;

    logic [3:0]     ptr_q, ptr_d;
    logic [15:0]    window_q, window_d;
    logic           step_q, step_d;

    logic           press;
    logic           tick;
    logic           advance;

    // ------------------------------------------------------------------
    // Button synchronizer (two flops, clears on reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_next};
        end
    end

    assign btn_s = sync_q[1];

    // ------------------------------------------------------------------
    // Debounce: the synchronized level must disagree with the accepted
    // level for DEBOUNCE_CYCLES consecutive cycles before it is taken.
    // Any agreement in between restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = db_cnt_q;
        if (btn_s == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbMax) begin
            btn_db_d = btn_s;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db_q     <= 1'b0;
            btn_db_dly_q <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            btn_db_q     <= btn_db_d;
            btn_db_dly_q <= btn_db_q;
            db_cnt_q     <= db_cnt_d;
        end
    end

    // Only the debounced rising edge steps; releasing the button never does.
    assign press = btn_db_q & ~btn_db_dly_q;

    // ------------------------------------------------------------------
    // Auto-scroll timer: held at zero while disabled so that re-enabling
    // always starts a full period.
    // ------------------------------------------------------------------
    always_comb begin
        tcnt_d = '0;
        if (auto_en) begin
            tcnt_d = (tcnt_q == TMax) ? '0 : tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign tick = auto_en & (tcnt_q == TMax);

    // ------------------------------------------------------------------
    // Window pointer and registered outputs. The character registers load
    // from the incremented pointer on the same edge as ptr, so the window
    // and ptr always change together.
    // ------------------------------------------------------------------
    assign advance = press | tick;

    always_comb begin
        ptr_d    = ptr_q;
        window_d = window_q;
        step_d   = advance;
        if (advance) begin
            ptr_d    = ptr_q + 4'd1;
            window_d = window_of(ptr_q + 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= 4'd0;
            window_q <= window_of(4'd0);
            step_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            window_q <= window_d;
            step_q   <= step_d;
        end
    end

    assign char3 = window_q[15:12];
    assign char2 = window_q[11:8];
    assign char1 = window_q[7:4];
    assign char0 = window_q[3:0];
    assign ptr   = ptr_q;
    assign step  = step_q;

endmodule
